// File: rtl/div_iter_unit_pkg.sv
// divider_pkg: shared types and constants for the iterative divider.
// State encoding, result layout indices and the divide-by-zero quotient.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // result_o is split in halves: index * WIDTH selects the half
  localparam int QUO_IDX = 0;
  localparam int REM_IDX = 1;

  // Divide-by-zero quotient (all ones), sliced to the operand width
  localparam logic [127:0] DZ_QUO = '1;

endpackage

// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: EX-stage <-> divider request/result handshake.
// master = EX stage (valid/ops/annul/ack), slave = divider (result/status).
interface div_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic               valid_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic               ack_i;
  logic [2*WIDTH-1:0] result_o;
  logic               done_o;
  logic               busy_o;
  logic               stall_o;

  modport master (
    output valid_i, signed_i, opdata1_i, opdata2_i,
    output annul_i, ack_i,
    input  result_o, done_o, busy_o, stall_o
  );

  modport slave (
    input  valid_i, signed_i, opdata1_i, opdata2_i,
    input  annul_i, ack_i,
    output result_o, done_o, busy_o, stall_o
  );
endinterface

// File: rtl/div_iter_unit_step.sv
// div_step: one combinational restoring-division step.
// In: rem_i, dvs_i, bit_i. Out: rem_o (new partial rem), q_o (quot bit).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] d;

  assign t     = {rem_i, bit_i};
  assign d     = t - {1'b0, dvs_i};
  assign q_o   = (t >= {1'b0, dvs_i});
  assign rem_o = q_o ? d[WIDTH-1:0] : t[WIDTH-1:0];
endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: radix-2^BPC restoring divider, {rem,quot} on bus.result_o.
// Ports: clk, rst (sync, high), bus (slave). Option: DIV_ZERO_FAST_EN.
module div_iter_unit
  import divider_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  div_iter_unit_if.slave bus
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = $clog2(N) + 1;

  div_state_t state, state_n;

  logic [WIDTH-1:0]   dvd, dvs, rem, op1;
  logic [CW-1:0]      cnt;
  logic               q_neg, r_neg, dz;
  logic [2*WIDTH-1:0] result;

  logic accept, ld_res, ld_dz, last, div_zero;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] abs1, abs2;

  logic [WIDTH-1:0] r_ch [BPC+1];
  logic [BPC-1:0]   q_ch;
  logic [WIDTH-1:0] dvd_n;
  logic [WIDTH-1:0] quo_f, rem_f;
  logic [2*WIDTH-1:0] result_f;
  logic [2*WIDTH-1:0] result_dz;

  assign a_neg    = bus.signed_i & bus.opdata1_i[WIDTH-1];
  assign b_neg    = bus.signed_i & bus.opdata2_i[WIDTH-1];
  // -2^(W-1) negates to itself, which is the correct unsigned magnitude
  assign abs1     = a_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2     = b_neg ? -bus.opdata2_i : bus.opdata2_i;
  assign div_zero = (bus.opdata2_i == '0);
  assign last     = (cnt == CW'(N - 1));

  assign r_ch[0] = rem;
  for (genvar i = 0; i < BPC; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (r_ch[i]),
      .dvs_i (dvs),
      .bit_i (dvd[WIDTH-1-i]),
      .rem_o (r_ch[i+1]),
      .q_o   (q_ch[BPC-1-i])
    );
  end

  // Dividend bits shift out the top; quotient bits fill in from the bottom
  assign dvd_n = {dvd[WIDTH-1-BPC:0], q_ch};

  assign quo_f = dz ? DZ_QUO[WIDTH-1:0]
                    : (q_neg ? -dvd_n : dvd_n);
  assign rem_f = dz ? op1
                    : (r_neg ? -r_ch[BPC] : r_ch[BPC]);

  always_comb begin
    result_f = '0;
    result_f[QUO_IDX*WIDTH +: WIDTH] = quo_f;
    result_f[REM_IDX*WIDTH +: WIDTH] = rem_f;
    result_dz = '0;
    result_dz[QUO_IDX*WIDTH +: WIDTH] = DZ_QUO[WIDTH-1:0];
    result_dz[REM_IDX*WIDTH +: WIDTH] = bus.opdata1_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    ld_res  = 1'b0;
    ld_dz   = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (bus.valid_i & ~bus.annul_i) begin
          accept  = 1'b1;
          state_n = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (div_zero) begin
            ld_dz   = 1'b1;
            state_n = DONE;
          end
`endif
        end
      end
      state == BUSY: begin
        if (bus.annul_i) begin
          state_n = IDLE;
        end else if (last) begin
          ld_res  = 1'b1;
          state_n = DONE;
        end
      end
      state == DONE: begin
        if (bus.annul_i | bus.ack_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      op1    <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dz     <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        dvd   <= abs1;
        dvs   <= abs2;
        rem   <= '0;
        op1   <= bus.opdata1_i;
        cnt   <= '0;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        dz    <= div_zero;
      end else if (state == BUSY) begin
        dvd <= dvd_n;
        rem <= r_ch[BPC];
        cnt <= cnt + 1'b1;
      end
      if (ld_res) result <= result_f;
      if (ld_dz)  result <= result_dz;
    end
  end

  assign bus.result_o = result;
  assign bus.done_o   = (state == DONE);
  assign bus.busy_o   = (state != IDLE);
  assign bus.stall_o  = bus.valid_i & ~bus.done_o;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed checks of div_iter_unit, BPC=1 and BPC=2.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero latency.
module tb_div_iter_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_iter_unit_if #(.WIDTH(32)) if1 ();
  div_iter_unit_if #(.WIDTH(32)) if2 ();

  div_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  div_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic v, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ak, input logic an);
    if (s) begin
      if2.valid_i = v; if2.signed_i = sg;
      if2.opdata1_i = a; if2.opdata2_i = b;
      if2.ack_i = ak; if2.annul_i = an;
    end else begin
      if1.valid_i = v; if1.signed_i = sg;
      if1.opdata1_i = a; if1.opdata2_i = b;
      if1.ack_i = ak; if1.annul_i = an;
    end
  endtask

  function automatic logic get_done(input bit s);
    return s ? if2.done_o : if1.done_o;
  endfunction

  function automatic logic get_busy(input bit s);
    return s ? if2.busy_o : if1.busy_o;
  endfunction

  function automatic logic get_stall(input bit s);
    return s ? if2.stall_o : if1.stall_o;
  endfunction

  function automatic logic [63:0] get_res(input bit s);
    return s ? if2.result_o : if1.result_o;
  endfunction

  // Call just after a rising edge; that cycle is cycle 0 (accept cycle).
  task automatic run(input bit s, input logic sg,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input int elat, input int hold, input string tag);
    int lat;
    logic [63:0] res;
    lat = 0;
    drive(s, 1'b1, sg, a, b, 1'b0, 1'b0);
    #1;
    chk({tag, ":stall0"}, 64'(get_stall(s)), 64'd1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1)
        drive(s, 1'b1, ~sg, $urandom, $urandom, 1'b0, 1'b0);
      if (get_done(s)) begin
        lat = k;
        break;
      end
      chk({tag, ":stall"}, 64'(get_stall(s)), 64'd1);
    end
    chk({tag, ":lat"}, 64'(lat), 64'(elat));
    chk({tag, ":stall_done"}, 64'(get_stall(s)), 64'd0);
    res = get_res(s);
    chk({tag, ":res"}, res, {er, eq});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_done"}, 64'(get_done(s)), 64'd1);
      chk({tag, ":hold_res"}, get_res(s), {er, eq});
    end
    if (s) if2.ack_i = 1'b1; else if1.ack_i = 1'b1;
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk({tag, ":ack_done"}, 64'(get_done(s)), 64'd0);
    chk({tag, ":ack_busy"}, 64'(get_busy(s)), 64'd0);
    chk({tag, ":idle_res"}, get_res(s), {er, eq});
    @(posedge clk); #1;
  endtask

  initial begin
    int dz_lat;
    bit seen;
`ifdef DIV_ZERO_FAST_EN
    dz_lat = 1;
`else
    dz_lat = 33;
`endif
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", if1.result_o, 64'd0);
    chk("rst_done", 64'(if1.done_o), 64'd0);
    chk("rst_busy", 64'(if1.busy_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0, "u100_7");
    run(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF,
        33, 0, "s-7_2");
    run(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,
        33, 0, "smin_-1");
    run(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,
        33, 0, "s7_-2");
    run(1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0,
        33, 0, "umax_1");
    run(1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5,
        dz_lat, 0, "u5_0");
    run(1'b0, 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9,
        dz_lat, 0, "s-7_0");

    // annul in IDLE blocks acceptance
    drive(1'b0, 1'b1, 1'b0, 32'd9, 32'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("annul_idle_busy", 64'(if1.busy_o), 64'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // annul in cycle 10 of BUSY
    drive(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (if1.done_o) seen = 1'b1;
    end
    chk("annul_busy10", 64'(if1.busy_o), 64'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("annul_idle11", 64'(if1.busy_o), 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (if1.done_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("annul_no_done", 64'(seen), 64'd0);
    run(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0, "u9_3");

    // BPC=2 with ack held off for 5 cycles
    run(1'b1, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hC0000001, 32'd1,
        17, 5, "b2_s");
    run(1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 17, 0, "b2_u");

    // reset in cycle 5 of BUSY
    drive(1'b0, 1'b1, 1'b0, 32'd50, 32'd5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_busy_pre", 64'(if1.busy_o), 64'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", 64'(if1.busy_o), 64'd0);
    chk("rst_mid_res", if1.result_o, 64'd0);
    chk("rst_mid_done", 64'(if1.done_o), 64'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Parametrised iterative integer divider for the EX stage of the pipeline. It replaces the fixed 32-bit divider wrapper with a single block that takes a handshaked request, latches its operands, and runs a radix-2^k restoring division. It returns a `{remainder, quotient}` pair for the HI/LO path and drives the EX-stage stall while busy. It supports signed and unsigned operation, configurable width and bits-per-cycle, annulment on exception/flush, and defined divide-by-zero results.

## Interface
- `WIDTH`, 32, operand width; even, ≥ 8.
- `BITS_PER_CYCLE`, 1, quotient bits retired per iteration; 1 or 2; must divide `WIDTH`.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset rst, synchronous, active-high.
- `valid_i` input 1: EX holds a DIV/DIVU; level, held until `done_o`/`ack_i`.
- `signed_i` input 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- `opdata1_i` input WIDTH: dividend; sampled at accept.
- `opdata2_i` input WIDTH: divisor; sampled at accept.
- `annul_i` input 1: flush/exception; abort current operation.
- `ack_i` input 1: pipeline advanced past EX this cycle; consumes result.
- `result_o` output 2*WIDTH: `{remainder, quotient}`; remainder in the upper half.
- `done_o` output 1: `result_o` valid.
- `busy_o` output 1: state is not IDLE.
- `stall_o` output 1: `valid_i & ~done_o`; combinational.

## Operation
- States are IDLE, BUSY, DONE. Reset → IDLE with `result_o`=0, `done_o`=0, `busy_o`=0.
- **IDLE:**
  - Accepts when `valid_i & ~annul_i`.
  - Latches `|dividend|` and `|divisor|` (absolute values when signed), sign of quotient = sign1 ^ sign2, sign of remainder = sign1.
  - Clears the partial remainder and iteration counter → BUSY.
- **BUSY:**
  - Each cycle performs `BITS_PER_CYCLE` shift/compare/subtract steps.
  - After N = `WIDTH`/`BITS_PER_CYCLE` cycles, applies sign fix-up, registers `result_o` → DONE.
- **DONE:**
  - `done_o`=1 and `result_o` is held stable.
  - On `ack_i` → IDLE with `done_o`=0. A new request requires a fresh IDLE cycle.
  - `result_o` keeps its last value in IDLE.
- **annul_i** in BUSY or DONE → IDLE next cycle, no result, `done_o`=0 next cycle. `annul_i` in IDLE blocks acceptance.
- If `annul_i` and `ack_i` are both high in DONE, annul wins (same resulting state).
- `rst` mid-operation → IDLE; all outputs take their reset values.
- **Arithmetic:**
  - The absolute value of -2^(WIDTH-1) is held in a WIDTH-bit unsigned register; no extra bit is needed.
  - Signed -2^(WIDTH-1) / -1 gives quotient 0x80..0 and remainder 0.
  - Quotient truncates toward zero. The remainder takes the dividend's sign.
- **Divide by zero:** quotient = all ones, remainder = `opdata1_i` as latched, for both signed and unsigned, in every configuration.
- Operand inputs may change after accept without effect.

## Timing
- Accept edge = cycle 0. `done_o` is first high in cycle N+1 (WIDTH=32: cycle 33 for BPC=1, cycle 17 for BPC=2).
- `stall_o` is high from the first cycle of `valid_i` until the `done_o` cycle, which is unstalled.
- Back-to-back operations: at least one IDLE cycle between `ack_i` and the next accept.
- Throughput: one division per N+2 cycles minimum.

## Configuration
- `DIV_ZERO_FAST_EN`
  - **Defined:** a zero divisor is detected at accept. The block goes IDLE → DONE directly, `done_o` is high in cycle 1, and the result is the divide-by-zero value above.
  - **Undefined:** a zero divisor runs the full N iterations and is overridden at fix-up. The result value is identical; only latency differs.

## Structure
- Package `divider_pkg` holds:
  - state encoding: IDLE, BUSY, DONE;
  - result-layout index constants (quotient low half, remainder high half);
  - the divide-by-zero quotient constant.
- Sub-module `div_step` is combinational: one restoring step taking partial remainder, divisor and incoming bit, returning the new remainder and quotient bit. It is instantiated `BITS_PER_CYCLE` times in a chain.

## Test plan
- WIDTH=32, BPC=1, unsigned 100 / 7 → quotient 14, remainder 2. `done_o` in cycle 33. `stall_o` is high in cycles 0–32 and low in cycle 33.
- Signed -7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Unsigned 5 / 0 → quotient 0xFFFFFFFF, remainder 5:
  - with `DIV_ZERO_FAST_EN`, `done_o` in cycle 1;
  - without it, `done_o` in cycle 33.
- `annul_i` pulsed in cycle 10 of BUSY → IDLE in cycle 11 with `done_o` never asserted. A following unsigned 9 / 3 returns quotient 3, remainder 0.
- BPC=2, signed 0x7FFFFFFF / 0xFFFFFFFE → quotient 0xC0000001, remainder 1, `done_o` in cycle 17. `ack_i` held low for 5 cycles → `result_o` stable and `done_o` high throughout.
- `rst` asserted in cycle 5 of BUSY → IDLE next cycle with `result_o`=0 and `busy_o`=0.
